// File: rtl/tx_scrambler_gearbox.sv
// ----------------------------------------------------------------------------
// tx_scrambler_gearbox
//
// TX PCS stage that sits right after the 64B/66B encoder. Each accepted
// 66-bit block has its 64-bit payload scrambled with x^58 + x^39 + 1
// (self-synchronising). The 2-bit sync header is left untouched. The
// resulting 66-bit stream is then cut into 32-bit PMA words by a
// bit-accurate gearbox.
//
// Ports:
//   tx_clk             in   1   block clock
//   tx_rst             in   1   asynchronous, active-high reset
//   encoded_data_in    in  66   [65:64] sync header, [63:0] payload (bit 0 first)
//   encoded_valid_in   in   1   block present
//   encoded_ready_out  out  1   stage can take a block (function of fill count only)
//   pma_data_out       out 32   PMA word, bit 0 transmitted first
//   pma_valid_out      out  1   PMA word present
//   pma_ready_in       in   1   PMA consumes the word
//
// Handshake: on both sides a transfer happens on a rising edge where valid
// and ready are both high. A producer holding valid keeps its data stable
// until that transfer. encoded_ready_out never looks at pma_ready_in, so
// there is no combinational path from any input to any output.
// ----------------------------------------------------------------------------
module tx_scrambler_gearbox #(
    parameter bit          SCRAMBLE_EN    = 1'b1,
    parameter logic [57:0] SCR_SEED       = 58'h3FF_FFFF_FFFF_FFFF,
    parameter int          PCS_DATA_WIDTH = 66,
    parameter int          PMA_DATA_WIDTH = 32
) (
    input  logic                      tx_clk,
    input  logic                      tx_rst,
    input  logic [PCS_DATA_WIDTH-1:0] encoded_data_in,
    input  logic                      encoded_valid_in,
    output logic                      encoded_ready_out,
    output logic [PMA_DATA_WIDTH-1:0] pma_data_out,
    output logic                      pma_valid_out,
    input  logic                      pma_ready_in
);

    // Parallel form of the serial scrambler. ext[57:0] holds the previous
    // 58 scrambled bits (ext[57] newest); ext[58+i] is scrambled payload
    // bit i. Only the newly produced 64 bits are returned; their top 58
    // bits form the history for the next block.
    function automatic logic [63:0] scr_step(input logic [57:0] hist,
                                             input logic [63:0] d);
        logic [121:0] ext;
        ext        = '0;
        ext[57:0]  = hist;
        for (int i = 0; i < 64; i++) begin
            ext[58+i] = d[i] ^ ext[19+i] ^ ext[i];
        end
        return ext[121:58];
    endfunction

    logic [127:0] r_buf;
    logic [7:0]   r_cnt;
    logic [57:0]  r_scr;
    logic [31:0]  r_pma_data;
    logic         r_pma_valid;

    logic [63:0]  w_scr_out;
    logic [63:0]  w_payload;
    logic [65:0]  w_stream;
    logic         w_push;
    logic         w_pop;
    logic [127:0] w_shifted;
    logic [7:0]   w_base;
    logic [127:0] w_keep_mask;
    logic [127:0] w_buf_next;
    logic [7:0]   w_cnt_next;

    assign encoded_ready_out = (r_cnt <= 8'd62);
    assign pma_data_out      = r_pma_data;
    assign pma_valid_out     = r_pma_valid;

    assign w_push = encoded_valid_in && encoded_ready_out;
    assign w_pop  = r_pma_valid && pma_ready_in;

    assign w_scr_out = scr_step(r_scr, encoded_data_in[63:0]);
    assign w_payload = SCRAMBLE_EN ? w_scr_out : encoded_data_in[63:0];
    // Header sits in the low bits so it leaves the gearbox first.
    assign w_stream  = {w_payload, encoded_data_in[65:64]};

    // A pop shifts the buffer before the new block is written, so the write
    // offset is the post-shift fill level.
    assign w_shifted = w_pop ? {32'b0, r_buf[127:32]} : r_buf;
    assign w_base    = w_pop ? (r_cnt - 8'd32) : r_cnt;

    // Bits at or above the fill level are stale; mask them so the new block
    // lands on clean bits.
    assign w_keep_mask = (128'd1 << w_base) - 128'd1;

    always_comb begin
        w_buf_next = w_shifted;
        if (w_push) begin
            w_buf_next = (w_shifted & w_keep_mask) | ({62'b0, w_stream} << w_base);
        end
    end

    assign w_cnt_next = r_cnt - (w_pop ? 8'd32 : 8'd0) + (w_push ? 8'd66 : 8'd0);

    always_ff @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst) begin
            r_buf       <= '0;
            r_cnt       <= '0;
            r_scr       <= SCR_SEED;
            r_pma_data  <= '0;
            r_pma_valid <= 1'b0;
        end else begin
            r_buf       <= w_buf_next;
            r_cnt       <= w_cnt_next;
            // History only moves on an accepted block; frozen in bypass.
            if (w_push && SCRAMBLE_EN) begin
                r_scr <= w_scr_out[63:6];
            end
            r_pma_data  <= w_buf_next[31:0];
            r_pma_valid <= (w_cnt_next >= 8'd32);
        end
    end

endmodule

// File: tb/tb_tx_scrambler_gearbox.sv
module tb_tx_scrambler_gearbox;

  localparam logic [57:0] SEED = 58'h3FF_FFFF_FFFF_FFFF;

  // ---------------- clock / reset ----------------
  logic tx_clk = 1'b0;
  logic tx_rst = 1'b1;
  always #5 tx_clk = ~tx_clk;

  logic [65:0] enc_data  = '0;
  logic        enc_valid = 1'b0;
  logic        pma_ready = 1'b0;

  logic        enc_ready_b, enc_ready_s;
  logic        valid_b, valid_s;
  logic [31:0] data_b, data_s;

  tx_scrambler_gearbox #(.SCRAMBLE_EN(1'b0), .SCR_SEED(SEED)) dut_b (
    .tx_clk            (tx_clk),
    .tx_rst            (tx_rst),
    .encoded_data_in   (enc_data),
    .encoded_valid_in  (enc_valid),
    .encoded_ready_out (enc_ready_b),
    .pma_data_out      (data_b),
    .pma_valid_out     (valid_b),
    .pma_ready_in      (pma_ready)
  );

  tx_scrambler_gearbox #(.SCRAMBLE_EN(1'b1), .SCR_SEED(SEED)) dut_s (
    .tx_clk            (tx_clk),
    .tx_rst            (tx_rst),
    .encoded_data_in   (enc_data),
    .encoded_valid_in  (enc_valid),
    .encoded_ready_out (enc_ready_s),
    .pma_data_out      (data_s),
    .pma_valid_out     (valid_s),
    .pma_ready_in      (pma_ready)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_b_q[$];
  logic [31:0] exp_s_q[$];
  bit          bits_b[$];
  bit          bits_s[$];
  bit          hist_q[$];   // hist_q[0] oldest scrambled bit

  int n_checks = 0;
  int n_pass   = 0;
  int n_push   = 0;
  int n_pop    = 0;
  bit saw_ready_low = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_clear();
    exp_b_q.delete();
    exp_s_q.delete();
    bits_b.delete();
    bits_s.delete();
    hist_q.delete();
    for (int k = 0; k < 58; k++) hist_q.push_back(SEED[k]);
  endtask

  task automatic model_push(input logic [65:0] blk);
    bit          o;
    logic [31:0] w;
    bits_b.push_back(blk[64]);
    bits_b.push_back(blk[65]);
    bits_s.push_back(blk[64]);
    bits_s.push_back(blk[65]);
    for (int i = 0; i < 64; i++) begin
      bits_b.push_back(blk[i]);
      o = blk[i] ^ hist_q[19] ^ hist_q[0];
      hist_q.push_back(o);
      void'(hist_q.pop_front());
      bits_s.push_back(o);
    end
    while (bits_b.size() >= 32) begin
      w = '0;
      for (int b = 0; b < 32; b++) w[b] = bits_b.pop_front();
      exp_b_q.push_back(w);
    end
    while (bits_s.size() >= 32) begin
      w = '0;
      for (int b = 0; b < 32; b++) w[b] = bits_s.pop_front();
      exp_s_q.push_back(w);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic reset_dut();
    tx_rst    = 1'b1;
    enc_valid = 1'b0;
    pma_ready = 1'b0;
    @(posedge tx_clk);
    #1;
    tx_rst = 1'b0;
    model_clear();
  endtask

  // Checks outputs against the model, then advances one edge.
  task automatic cycle(output bit pushed);
    bit push, pop;
    int mc;
    mc = 32 * exp_b_q.size() + bits_b.size();
    check("ready_b", enc_ready_b, mc <= 62);
    check("ready_s", enc_ready_s, mc <= 62);
    check("valid_b", valid_b, mc >= 32);
    check("valid_s", valid_s, mc >= 32);
    push = enc_valid && enc_ready_b;
    pop  = valid_b && pma_ready;
    if (pop) begin
      if (exp_b_q.size() == 0) check("word_b_underflow", 1, 0);
      else check("word_b", data_b, exp_b_q.pop_front());
      if (exp_s_q.size() == 0) check("word_s_underflow", 1, 0);
      else check("word_s", data_s, exp_s_q.pop_front());
      n_pop++;
    end
    if (push) begin
      model_push(enc_data);
      n_push++;
    end
    pushed = push;
    @(posedge tx_clk);
    #1;
  endtask

  task automatic run(input int ncyc, input int st, input int sl, input bit zero, input int max_push);
    logic [31:0] held_b, held_s;
    logic        held_v;
    bit          stall, prev_stall, need_new, p;
    prev_stall = 1'b0;
    need_new   = 1'b1;
    held_b = '0; held_s = '0; held_v = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      stall     = (k >= st) && (k < st + sl);
      pma_ready = !stall;
      if (n_push >= max_push) begin
        enc_valid = 1'b0;
      end else begin
        enc_valid = 1'b1;
        if (need_new) begin
          enc_data = zero ? {2'b01, 64'h0}
                          : {2'($urandom_range(1, 2)), $urandom, $urandom};
          need_new = 1'b0;
        end
      end
      if (stall && prev_stall) begin
        check("stall_hold_b", data_b, held_b);
        check("stall_hold_s", data_s, held_s);
        check("stall_hold_v", valid_b, held_v);
      end
      if (stall && !enc_ready_b) saw_ready_low = 1'b1;
      held_b = data_b;
      held_s = data_s;
      held_v = valid_b;
      prev_stall = stall;
      cycle(p);
      if (p) need_new = 1'b1;
    end
    enc_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  initial begin
    bit p;
    int blocks;
    model_clear();
    #1;
    // reset state, still inside reset
    check("rst_valid_b", valid_b, 0);
    check("rst_valid_s", valid_s, 0);
    check("rst_data_b", data_b, 0);
    check("rst_ready_b", enc_ready_b, 1);

    // directed single block, bypass instance
    reset_dut();
    enc_data  = {2'b01, 64'h0123_4567_89AB_CDEF};
    enc_valid = 1'b1;
    pma_ready = 1'b1;
    cycle(p);
    enc_valid = 1'b0;
    check("dir_w0", data_b, 32'h26AF_37BD);
    check("dir_w0_valid", valid_b, 1);
    cycle(p);
    check("dir_w1", data_b, 32'h048D_159E);
    cycle(p);
    check("dir_drop", valid_b, 0);
    check("dir_cnt", dut_b.r_cnt, 2);
    cycle(p);

    // steady-state rate
    reset_dut();
    n_push = 0;
    n_pop  = 0;
    run(330, 1000, 0, 1'b0, 1 << 30);
    blocks = n_push;
    check("rate_blocks", blocks, 160);
    run(1, 1000, 0, 1'b0, 1 << 30);
    check("rate_words", n_pop, 330);

    // backpressure
    reset_dut();
    n_push = 0;
    saw_ready_low = 1'b0;
    run(40, 12, 10, 1'b0, 1 << 30);
    check("bp_ready_fell", saw_ready_low, 1);
    run(6, 1000, 0, 1'b0, 0);

    // scrambler, all-zero blocks from the all-ones seed
    reset_dut();
    n_push = 0;
    enc_data  = {2'b01, 64'h0};
    enc_valid = 1'b1;
    pma_ready = 1'b1;
    cycle(p);
    check("scr_w0", data_s, 32'h0000_0001);
    check("scr_w0_byp", data_b, 32'h0000_0001);
    cycle(p);
    check("scr_w1", data_s, 32'h0FFF_FE00);
    check("scr_w1_byp", data_b, 32'h0000_0000);
    run(20, 2, 5, 1'b1, 4);
    check("scr_blocks", n_push, 4);

    // asynchronous reset with 34 bits buffered
    reset_dut();
    n_push = 0;
    enc_data  = {2'b01, 64'h0123_4567_89AB_CDEF};
    enc_valid = 1'b1;
    pma_ready = 1'b0;
    cycle(p);
    enc_valid = 1'b0;
    pma_ready = 1'b1;
    cycle(p);
    check("ar_pre_cnt", dut_b.r_cnt, 34);
    check("ar_pre_valid", valid_b, 1);
    #2;
    tx_rst = 1'b1;
    #1;
    check("ar_valid_b", valid_b, 0);
    check("ar_valid_s", valid_s, 0);
    check("ar_ready_b", enc_ready_b, 1);
    check("ar_data_b", data_b, 0);
    #2;
    tx_rst = 1'b0;
    model_clear();
    enc_data  = {2'b01, 64'h0};
    enc_valid = 1'b1;
    cycle(p);
    check("ar_post_w0_s", data_s, 32'h0000_0001);
    check("ar_post_w0_b", data_b, 32'h0000_0001);
    cycle(p);
    check("ar_post_w1_s", data_s, 32'h0FFF_FE00);
    run(12, 1000, 0, 1'b1, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tx_scrambler_gearbox.md
Name: tx_scrambler_gearbox

Overview:
- TX PCS stage directly downstream of the 64B/66B encoder.
- Accepts 66-bit encoded blocks over a valid/ready handshake.
- Scrambles the 64-bit payload with the self-synchronising polynomial x^58 + x^39 + 1; the 2-bit sync header passes unscrambled.
- Serialises the 66-bit stream into 32-bit PMA words through a bit-accurate gearbox, with valid/ready on the PMA side.

Parameters:
- SCRAMBLE_EN, 1, 1 = scramble payload; 0 = bypass (payload passes unchanged, scrambler state frozen).
- SCR_SEED, 58'h3FF_FFFF_FFFF_FFFF, scrambler state loaded at reset.
- PCS_DATA_WIDTH, 66, encoded block width (fixed at 66).
- PMA_DATA_WIDTH, 32, output word width (fixed at 32).

Ports:
- tx_clk  in  1  single clock for the block.
- tx_rst  in  1  reset; asynchronous assertion, active-high.
- encoded_data_in  in  66  [65:64] sync header, [63:0] payload, payload bit 0 transmitted first.
- encoded_valid_in  in  1  block present.
- encoded_ready_out  out  1  block accepted when valid && ready at a rising edge.
- pma_data_out  out  32  bit 0 transmitted first.
- pma_valid_out  out  1  word present.
- pma_ready_in  in  1  word consumed when valid && ready at a rising edge.

Behaviour:
- Reset (tx_rst high, asynchronous):
  - buffer cleared, fill count = 0, scrambler state = SCR_SEED.
  - pma_data_out = 0, pma_valid_out = 0, encoded_ready_out = 1.
  - Mid-operation reset discards all buffered bits and any partial word.
  - First accept is allowed on the first rising edge after deassertion.
- Scrambler:
  - Serial equivalent, for i = 0..63 in order: out_i = d_i ^ out_(i-39) ^ out_(i-58), where out_(i-k) with i < k is taken from the 58-bit history of previous scrambled bits.
  - Implemented as one 64-bit parallel step per accepted block.
  - History advances only on an accepted block, never on a stall.
  - Sync header is never scrambled. Header values 00/11 pass unchanged; no error checking.
- Stream order: the accepted block forms stream S[65:0] = {scrambled_payload[63:0], header[1:0]}. S[0] is header bit 0 and goes out first.
- Buffer and fill count:
  - 128-bit buffer, 8-bit fill count cnt (0..128). Buffered bits are LSB-aligned; buf[0] is the oldest bit.
  - pma_valid_out = registered (cnt >= 32); pma_data_out = registered buf[31:0].
  - encoded_ready_out = (cnt <= 62), combinational from the count register only. It does not depend on pma_ready_in and has no combinational input-to-output path.
- Per rising edge, with pop = pma_valid_out && pma_ready_in and push = encoded_valid_in && encoded_ready_out:
  - pop only: buffer shifts right 32; cnt -= 32.
  - push only: S is written at bit offset cnt; cnt += 66.
  - pop and push in the same edge: shift first, write S at offset cnt-32; cnt += 34.
  - Maximum occupancy is 62 + 66 = 128, so there is no overflow. Buffer bits above cnt are don't-care, but must not corrupt later writes.
- Latency: with cnt = 0, a block accepted at edge N gives its first word valid after edge N (one cycle). The second word follows on the next pop.
- Throughput with pma_ready_in held high: one word per cycle after fill, exactly 16 blocks per 33 words. encoded_ready_out deasserts periodically to absorb the 66/64 rate difference.
- Backpressure: pma_ready_in low holds pma_data_out and pma_valid_out stable. Pushes continue until cnt > 62.
- Leftover bits (< 32) stay buffered indefinitely; there is no flush or idle padding (the encoder supplies idle blocks).

Test Plan:
- Reset directed word: SCRAMBLE_EN=0. Push {2'b01, 64'h0123_4567_89AB_CDEF}, pma_ready_in=1.
  - Words 32'h26AF_37BD then 32'h048D_159E.
  - cnt = 2, then pma_valid_out drops.
- Steady-state rate: SCRAMBLE_EN=0, continuous valid blocks, pma_ready_in=1 for 330 cycles after fill.
  - Exactly 160 blocks accepted, 330 words emitted.
  - Concatenated output bits equal the concatenated S streams, with no gaps.
- Backpressure: hold pma_ready_in low 10 cycles while valid blocks are offered.
  - encoded_ready_out falls once cnt > 62.
  - pma_data_out is stable throughout.
  - After release, the output bitstream is identical to the unstalled run.
- Scrambler: SCRAMBLE_EN=1, seed all-ones, 4 all-zero data blocks {2'b01, 64'h0}.
  - Output payload bits match the serial reference model.
  - Header bits stay 01.
  - Scrambler state is unchanged across stall cycles.
- Async reset mid-stream: assert tx_rst between clock edges with cnt = 34.
  - pma_valid_out = 0 and encoded_ready_out = 1 immediately, without waiting for a clock edge.
  - After release, the first word reflects only post-reset blocks.
  - Scrambler has restarted from SCR_SEED.
